mdu_ctl: RTL and testbench

- Sequencing controller for the multiply/divide unit (HI/LO) in the Execute stage. It sits beside the ALU and its ALU-op decoder.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO from E-stage control.
- Runs a fixed-latency multi-cycle operation and holds HI/LO.
- Raises a stall request to the hazard unit while any MDU-using instruction must wait.

---
 rtl/mdu_ctl_pkg.sv | 32 +++
 rtl/mdu_arith.sv | 89 ++++++++
 rtl/mdu_ctl.sv | 163 ++++++++++++++++
 tb/tb_mdu_ctl.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/mdu_ctl_pkg.sv
// -----------------------------------------------------------------------------
// mdu_ctl_pkg
// Shared definitions for the Execute-stage multiply/divide unit:
//   - MDUOP_* operation codes carried from the E-stage decoder (4 bits, NONE = 0)
//   - the controller state encoding
//   - a helper that recognises the ops that launch a multi-cycle operation
// -----------------------------------------------------------------------------
package mdu_ctl_pkg;

    localparam logic [3:0] MDUOP_NONE  = 4'd0;
    localparam logic [3:0] MDUOP_MULT  = 4'd1;
    localparam logic [3:0] MDUOP_MULTU = 4'd2;
    localparam logic [3:0] MDUOP_DIV   = 4'd3;
    localparam logic [3:0] MDUOP_DIVU  = 4'd4;
    localparam logic [3:0] MDUOP_MTHI  = 4'd5;
    localparam logic [3:0] MDUOP_MTLO  = 4'd6;
    localparam logic [3:0] MDUOP_MFHI  = 4'd7;
    localparam logic [3:0] MDUOP_MFLO  = 4'd8;

    typedef enum logic [1:0] {
        MDU_IDLE = 2'd0,
        MDU_MUL  = 2'd1,
        MDU_DIV  = 2'd2
    } mdu_state_t;

    // True for the four ops that occupy the unit for several cycles.
    function automatic logic is_start_op(input logic [3:0] op);
        return (op == MDUOP_MULT) || (op == MDUOP_MULTU) ||
               (op == MDUOP_DIV)  || (op == MDUOP_DIVU);
    endfunction

endpackage

// File: rtl/mdu_arith.sv
// -----------------------------------------------------------------------------
// mdu_arith
// Purely combinational HI/LO result generator for the captured MDU operation.
// Ports:
//   op       in   4   captured MDUOP_* code of the running operation
//   a        in  32   captured operand A (dividend / multiplicand)
//   b        in  32   captured operand B (divisor / multiplier)
//   hi_next  out 32   value to load into HI on completion
//   lo_next  out 32   value to load into LO on completion
//   wr       out  1   1 when HI/LO should actually be written (0 on divide by zero)
// -----------------------------------------------------------------------------
module mdu_arith
    import mdu_ctl_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] hi_next,
    output logic [31:0] lo_next,
    output logic        wr
);

    logic [63:0]        prod_s;
    logic [63:0]        prod_u;
    logic               div_zero;
    logic               div_ovf;
    logic [31:0]        b_sdiv;
    logic [31:0]        b_udiv;
    logic signed [31:0] q_s;
    logic signed [31:0] r_s;
    logic [31:0]        q_u;
    logic [31:0]        r_u;

    // Sign-extending to 64 bits before multiplying makes the low 64 bits of
    // the product the exact signed result.
    assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign prod_u = {32'd0, a} * {32'd0, b};

    assign div_zero = (b == 32'd0);
    assign div_ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);

    // The divisors are steered to 1 in the zero and signed-overflow cases so
    // the dividers never see an undefined operation; those results are
    // replaced or suppressed below anyway.
    assign b_sdiv = (div_zero || div_ovf) ? 32'd1 : b;
    assign b_udiv = div_zero ? 32'd1 : b;

    assign q_s = $signed(a) / $signed(b_sdiv);
    assign r_s = $signed(a) % $signed(b_sdiv);
    assign q_u = a / b_udiv;
    assign r_u = a % b_udiv;

    // Select the result for the captured op; divide by zero drops the write
    // so HI/LO keep their previous contents.
    always_comb begin
        hi_next = 32'd0;
        lo_next = 32'd0;
        wr      = 1'b0;
        case (op)
            MDUOP_MULT: begin
                {hi_next, lo_next} = prod_s;
                wr = 1'b1;
            end
            MDUOP_MULTU: begin
                {hi_next, lo_next} = prod_u;
                wr = 1'b1;
            end
            MDUOP_DIV: begin
                wr = !div_zero;
                if (div_ovf) begin
                    hi_next = 32'd0;
                    lo_next = 32'h8000_0000;
                end else begin
                    hi_next = r_s;
                    lo_next = q_s;
                end
            end
            MDUOP_DIVU: begin
                wr      = !div_zero;
                hi_next = r_u;
                lo_next = q_u;
            end
            default: begin
                wr = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/mdu_ctl.sv
// -----------------------------------------------------------------------------
// mdu_ctl
// Execute-stage sequencing controller for the HI/LO multiply/divide unit.
// Runs fixed-latency MULT/MULTU/DIV/DIVU, handles MTHI/MTLO/MFHI/MFLO and
// requests pipeline stalls while a following MDU instruction must wait.
// Ports:
//   clk        in   1   system clock, rising edge
//   rst_n      in   1   synchronous active-low reset
//   md_op      in   4   E-stage MDUOP_* code
//   md_valid   in   1   E-stage instruction is not a bubble
//   md_kill    in   1   E-stage instruction is being flushed this cycle
//   rs_val     in  32   forwarded operand A
//   rt_val     in  32   forwarded operand B
//   d_uses_md  in   1   D-stage instruction is an MDU op
//   busy       out  1   multi-cycle operation in progress
//   md_stall   out  1   stall request to the hazard unit
//   md_rdata   out 32   MFHI/MFLO read data (0 for other ops)
//   hi         out 32   architectural HI
//   lo         out 32   architectural LO
// -----------------------------------------------------------------------------
module mdu_ctl
    import mdu_ctl_pkg::*;
#(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
)(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  md_op,
    input  logic        md_valid,
    input  logic        md_kill,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        d_uses_md,
    output logic        busy,
    output logic        md_stall,
    output logic [31:0] md_rdata,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int CNT_W = 16;

    mdu_state_t       state;
    mdu_state_t       state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic [3:0]       op_q;
    logic [31:0]      a_q;
    logic [31:0]      b_q;
    logic             idle;
    logic             op_ok;
    logic             start_acc;
    logic             mthi_we;
    logic             mtlo_we;
    logic             done;
    logic [31:0]      arith_hi;
    logic [31:0]      arith_lo;
    logic             arith_wr;

    // Any op arriving while the unit is busy is ignored outright, which is
    // why op_ok requires IDLE in addition to a live, unflushed instruction.
    assign idle      = (state == MDU_IDLE);
    assign op_ok     = md_valid && !md_kill && idle;
    assign start_acc = op_ok && is_start_op(md_op);
    assign mthi_we   = op_ok && (md_op == MDUOP_MTHI);
    assign mtlo_we   = op_ok && (md_op == MDUOP_MTLO);
    assign done      = !idle && (cnt == '0);

    assign busy     = !idle;
    assign md_stall = d_uses_md && (busy || start_acc);

    assign md_rdata = (md_op == MDUOP_MFHI) ? hi :
                      (md_op == MDUOP_MFLO) ? lo : 32'd0;

    mdu_arith u_arith (
        .op      (op_q),
        .a       (a_q),
        .b       (b_q),
        .hi_next (arith_hi),
        .lo_next (arith_lo),
        .wr      (arith_wr)
    );

    // Next-state logic: a start loads the counter with N-1 so that the
    // completion edge, taken when the counter reads 0, is exactly N edges
    // after the start edge.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            MDU_IDLE: begin
                if (start_acc) begin
                    if ((md_op == MDUOP_MULT) || (md_op == MDUOP_MULTU)) begin
                        state_next = MDU_MUL;
                        cnt_next   = CNT_W'(MUL_CYCLES - 1);
                    end else begin
                        state_next = MDU_DIV;
                        cnt_next   = CNT_W'(DIV_CYCLES - 1);
                    end
                end
            end
            MDU_MUL, MDU_DIV: begin
                if (cnt == '0) begin
                    state_next = MDU_IDLE;
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end
            default: begin
                state_next = MDU_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // State and counter register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= MDU_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Operands and op are frozen at the start edge so forwarding changes in
    // later cycles cannot disturb the running operation.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_q <= MDUOP_NONE;
            a_q  <= 32'd0;
            b_q  <= 32'd0;
        end else if (start_acc) begin
            op_q <= md_op;
            a_q  <= rs_val;
            b_q  <= rt_val;
        end
    end

    // HI/LO update: completion writes come only while busy and moves only
    // while idle, so the two sources never collide.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hi <= 32'd0;
            lo <= 32'd0;
        end else if (done) begin
            if (arith_wr) begin
                hi <= arith_hi;
                lo <= arith_lo;
            end
        end else begin
            if (mthi_we) begin
                hi <= rs_val;
            end
            if (mtlo_we) begin
                lo <= rs_val;
            end
        end
    end

endmodule

// File: tb/tb_mdu_ctl.sv
// -----------------------------------------------------------------------------
// tb_mdu_ctl
// Directed self-checking bench for mdu_ctl. Expected HI/LO results are pushed
// to a scoreboard queue when an operation is launched and popped when the
// operation is due to complete.
// -----------------------------------------------------------------------------
module tb_mdu_ctl;
    import mdu_ctl_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  md_op;
    logic        md_valid;
    logic        md_kill;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        d_uses_md;
    logic        busy;
    logic        md_stall;
    logic [31:0] md_rdata;
    logic [31:0] hi;
    logic [31:0] lo;

    int          total = 0;
    int          bad   = 0;
    logic [63:0] sb[$];
    logic [31:0] model_hi = 32'd0;
    logic [31:0] model_lo = 32'd0;

    mdu_ctl #(
        .MUL_CYCLES (5),
        .DIV_CYCLES (10)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .md_op     (md_op),
        .md_valid  (md_valid),
        .md_kill   (md_kill),
        .rs_val    (rs_val),
        .rt_val    (rt_val),
        .d_uses_md (d_uses_md),
        .busy      (busy),
        .md_stall  (md_stall),
        .md_rdata  (md_rdata),
        .hi        (hi),
        .lo        (lo)
    );

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    // Safety net so a stuck run still ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [3:0] op, input logic v, input logic k,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic du);
        md_op     = op;
        md_valid  = v;
        md_kill   = k;
        rs_val    = a;
        rt_val    = b;
        d_uses_md = du;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs,
                               input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Launch one multi-cycle op, check busy/stall in every busy cycle, check
    // HI/LO hold until the completion edge, then compare against the
    // scoreboard. With intrude set, an illegal MTHI is driven mid-operation.
    task automatic runOp(input string tag, input logic [3:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp, input int n,
                         input logic du, input logic intrude);
        logic [63:0] e;
        sb.push_back(exp);
        applyStimulus(op, 1'b1, 1'b0, a, b, du);
        #1;
        checkOutput({tag, " start stall"}, 64'(md_stall), 64'(du));
        tick;
        for (int k = 1; k <= n; k++) begin
            if (intrude && k == 2)
                applyStimulus(MDUOP_MTHI, 1'b1, 1'b0, 32'h0000_0099, 32'd0, du);
            else
                applyStimulus(MDUOP_NONE, 1'b0, 1'b0, 32'd0, 32'd0, du);
            #1;
            checkOutput({tag, " busy/stall"}, 64'({busy, md_stall}), 64'({1'b1, du}));
            checkOutput({tag, " hold"}, {hi, lo}, {model_hi, model_lo});
            tick;
        end
        applyStimulus(MDUOP_NONE, 1'b0, 1'b0, 32'd0, 32'd0, du);
        #1;
        checkOutput({tag, " released"}, 64'({busy, md_stall}), 64'd0);
        if (sb.size() == 0) begin
            total++;
            bad++;
            $error("[TB] FAIL %s scoreboard: observed=empty expected=entry", tag);
        end else begin
            e = sb.pop_front();
            checkOutput({tag, " hi/lo"}, {hi, lo}, e);
            {model_hi, model_lo} = e;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        applyStimulus(MDUOP_NONE, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
        tick;
        tick;
        checkOutput("reset state", {30'd0, busy, md_stall, hi}, {30'd0, 1'b0, 1'b0, 32'd0});
        checkOutput("reset lo", 64'(lo), 64'd0);
        rst_n = 1'b1;

        // Reset in the middle of a DIV aborts it and no late write appears.
        applyStimulus(MDUOP_DIV, 1'b1, 1'b0, 32'd100, 32'd7, 1'b0);
        tick;
        applyStimulus(MDUOP_NONE, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        tick;
        tick;
        checkOutput("div busy before reset", 64'(busy), 64'd1);
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        checkOutput("mid-div reset", {busy, hi, lo}, 65'd0);
        for (int i = 0; i < 12; i++) tick;
        checkOutput("no write after reset", {busy, hi, lo}, 65'd0);

        runOp("mult -3x5", MDUOP_MULT, 32'hFFFF_FFFD, 32'd5,
              {32'hFFFF_FFFF, 32'hFFFF_FFF1}, 5, 1'b1, 1'b0);
        runOp("multu", MDUOP_MULTU, 32'hFFFF_FFFF, 32'd2,
              {32'h0000_0001, 32'hFFFF_FFFE}, 5, 1'b0, 1'b0);
        runOp("div -7/2", MDUOP_DIV, 32'hFFFF_FFF9, 32'd2,
              {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 10, 1'b1, 1'b1);

        // Preset HI/LO through the move-to path.
        applyStimulus(MDUOP_MTHI, 1'b1, 1'b0, 32'h11, 32'd0, 1'b0);
        tick;
        applyStimulus(MDUOP_MTLO, 1'b1, 1'b0, 32'h22, 32'd0, 1'b0);
        tick;
        applyStimulus(MDUOP_NONE, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        #1;
        checkOutput("mthi/mtlo", {hi, lo}, {32'h11, 32'h22});
        {model_hi, model_lo} = {32'h11, 32'h22};

        runOp("divu by zero", MDUOP_DIVU, 32'd7, 32'd0,
              {32'h11, 32'h22}, 10, 1'b0, 1'b0);

        applyStimulus(MDUOP_MTHI, 1'b1, 1'b0, 32'hDEAD_BEEF, 32'd0, 1'b0);
        tick;
        applyStimulus(MDUOP_MFHI, 1'b1, 1'b0, 32'd0, 32'd0, 1'b0);
        #1;
        checkOutput("mfhi", 64'(md_rdata), 64'h0000_0000_DEAD_BEEF);
        applyStimulus(MDUOP_MFLO, 1'b1, 1'b0, 32'd0, 32'd0, 1'b0);
        #1;
        checkOutput("mflo", 64'(md_rdata), 64'h22);
        applyStimulus(MDUOP_NONE, 1'b1, 1'b0, 32'd0, 32'd0, 1'b0);
        #1;
        checkOutput("rdata idle", 64'(md_rdata), 64'd0);
        model_hi = 32'hDEAD_BEEF;

        // Killed move-to must not write.
        applyStimulus(MDUOP_MTLO, 1'b1, 1'b1, 32'h5555, 32'd0, 1'b0);
        tick;
        applyStimulus(MDUOP_NONE, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        #1;
        checkOutput("killed mtlo", {hi, lo}, {32'hDEAD_BEEF, 32'h22});

        // Killed start: no busy and no stall contribution.
        applyStimulus(MDUOP_DIV, 1'b1, 1'b1, 32'd100, 32'd7, 1'b1);
        #1;
        checkOutput("killed div stall", 64'(md_stall), 64'd0);
        tick;
        checkOutput("killed div busy", 64'({busy, md_stall}), 64'd0);
        applyStimulus(MDUOP_NONE, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        for (int i = 0; i < 12; i++) tick;
        checkOutput("killed div no write", {hi, lo}, {model_hi, model_lo});

        runOp("div overflow", MDUOP_DIV, 32'h8000_0000, 32'hFFFF_FFFF,
              {32'h0000_0000, 32'h8000_0000}, 10, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
